// File: rtl/vga_draw_master.sv
// vga_draw_master: queues pixel-draw requests and replays each as X/Y/COLOUR/STROBE register writes on the shared 8-bit bus
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-low reset
//   req_valid   draw request present
//   req_ready   request FIFO not full; accept on req_valid && req_ready
//   req_x       pixel X
//   req_y       pixel Y (frame-buffer address = {Y, X})
//   req_colour  colour byte
//   bus_addr    registered bus address
//   bus_data    bus data, driven only while bus_we=1, otherwise high-Z
//   bus_we      registered bus write enable
//   busy        FIFO non-empty or sequencer not idle
//   done        one-cycle pulse in the cycle after the STROBE write
//
// Optional feature: define DRAW_SKIP_REDUNDANT_EN to skip X/Y/COLOUR writes whose
// value matches the last one written (the STROBE write is always issued).
module vga_draw_master #(
  parameter logic [7:0] BASE_ADDR  = 8'hB0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [7:0] req_y,
  input  logic [7:0] req_colour,
  output logic [7:0] bus_addr,
  inout  wire  [7:0] bus_data,
  output logic       bus_we,
  output logic       busy,
  output logic       done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [3:0] {IDLE, WR_X, GAP_X, WR_Y, GAP_Y, WR_C, GAP_C, WR_S, GAP_S} state_t;
  state_t state, next, first, after_x, after_y;
  logic [23:0] mem [FIFO_DEPTH];
  logic [23:0] head;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic full, empty, push, pop;
  logic [7:0] wx, wy, wc, data_out;
  logic sk_x, sk_y, sk_c;
  assign full      = count == (AW+1)'(FIFO_DEPTH);
  assign empty     = count == '0;
  assign req_ready = !full;
  assign push      = req_valid && !full;
  // The head entry is consumed exactly when a new pixel sequence starts.
  assign pop       = !empty && (state == IDLE || state == GAP_S);
  assign head      = mem[rptr];
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {req_x, req_y, req_colour};
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(push);
      rptr  <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (pop) {wx, wy, wc} <= head;
  end
`ifdef DRAW_SKIP_REDUNDANT_EN
  logic [7:0] sh_x, sh_y, sh_c;
  logic v_x, v_y, v_c;
  logic [23:0] cand;
  // Skip decisions look at the entry being popped when starting a pixel,
  // and at the working registers while inside a pixel's sequence.
  assign cand = pop ? head : {wx, wy, wc};
  assign sk_x = v_x && cand[23:16] == sh_x;
  assign sk_y = v_y && cand[15:8] == sh_y;
  assign sk_c = v_c && cand[7:0] == sh_c;
  always_ff @(posedge clk) begin
    if (!reset) begin
      {v_x, v_y, v_c} <= '0;
    end else begin
      if (state == WR_X) begin
        sh_x <= wx;
        v_x  <= 1'b1;
      end
      if (state == WR_Y) begin
        sh_y <= wy;
        v_y  <= 1'b1;
      end
      if (state == WR_C) begin
        sh_c <= wc;
        v_c  <= 1'b1;
      end
    end
  end
`else
  assign sk_x = 1'b0;
  assign sk_y = 1'b0;
  assign sk_c = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    after_y = sk_c ? WR_S : WR_C;
    after_x = sk_y ? after_y : WR_Y;
    first   = sk_x ? after_x : WR_X;
    next    = IDLE;
    case (state)
      IDLE:    next = pop ? first : IDLE;
      WR_X:    next = GAP_X;
      GAP_X:   next = after_x;
      WR_Y:    next = GAP_Y;
      GAP_Y:   next = after_y;
      WR_C:    next = GAP_C;
      GAP_C:   next = WR_S;
      WR_S:    next = GAP_S;
      GAP_S:   next = pop ? first : IDLE;
      default: next = IDLE;
    endcase
  end
  // Bus controls are registered from the next state so they line up with the WR_* cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_we   <= 1'b0;
      bus_addr <= 8'h00;
    end else begin
      bus_we   <= next inside {WR_X, WR_Y, WR_C, WR_S};
      bus_addr <= next == WR_X ? BASE_ADDR :
                  next == WR_Y ? BASE_ADDR + 8'd1 :
                  next == WR_C ? BASE_ADDR + 8'd2 :
                  next == WR_S ? BASE_ADDR + 8'd3 : bus_addr;
    end
  end
  always_comb begin
    done     = state == GAP_S;
    busy     = !empty || state != IDLE;
    data_out = state == WR_X ? wx : state == WR_Y ? wy : state == WR_C ? wc : 8'h01;
  end
  assign bus_data = bus_we ? data_out : 'z;
endmodule
